grid_accum_ctrl: RTL and testbench
==================================

Name: grid_accum_ctrl

Overview:
- Read-modify-write accumulation controller for the gridding grid memory. Sits downstream of F.
- Accepts F's (valid, gind, outdatar, outdatai) stream, one sample per cycle, with no back-pressure. Adds each sample into grid RAM at address gind.
- Resolves read-after-write hazards by forwarding.
- Sequences grid clear and grid dump. Drives hold, which the top level ORs into F's FIFO empty, so F stops issuing during those operations.

Parameters:
- GRID_SIZE, 1024: number of grid cells.
- AW, 10: grid RAM address width; must equal clog2(GRID_SIZE).
- DW, 32: width of each real/imag accumulator.
- DRAIN_CYC, 8: consecutive cycles with valid=0 required before CLEAR/DUMP begins.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- valid  in  1  sample strobe from F
- gind  in  16  grid index from F
- outdatar  in  DW  real sample from F
- outdatai  in  DW  imag sample from F
- cmd_clear  in  1  pulse: zero whole grid
- cmd_dump  in  1  pulse: stream whole grid out
- hold  out  1  high = upstream must not read FIFOs
- busy  out  1  high in DRAIN/CLEAR/DUMP
- done  out  1  one-cycle pulse when CLEAR/DUMP finishes
- drop_err  out  1  sticky: a sample was discarded
- mem_ren  out  1  RAM read enable
- mem_raddr  out  AW  RAM read address
- mem_rdatar  in  DW  RAM real read data
- mem_rdatai  in  DW  RAM imag read data
- mem_wen  out  1  RAM write enable
- mem_waddr  out  AW  RAM write address
- mem_wdatar  out  DW  RAM real write data
- mem_wdatai  out  DW  RAM imag write data
- dump_valid  out  1  dump data strobe
- dump_addr  out  AW  dump cell index
- dump_datar  out  DW  dump real data
- dump_datai  out  DW  dump imag data

Behaviour:
- RAM contract: simple dual-port, registered read (data valid 1 cycle after mem_ren), read-first on address collision with a same-cycle write.
- Reset values: all outputs 0, state IDLE, forwarding entries invalid. RAM contents are untouched by reset.
- States: IDLE (accumulating), DRAIN, CLEAR, DUMP.
- IDLE accumulate pipeline:
  - Cycle t: valid=1 with gind<GRID_SIZE drives mem_ren=1 and mem_raddr=gind[AW-1:0] combinationally, and registers addr/data into S1.
  - Cycle t+1: base = forwarded value, else mem_rdata. Sum = base + sample, computed per component, modulo 2^DW (wrap, no saturation). Sum is registered into S2.
  - Cycle t+2: mem_wen=1, mem_waddr/mem_wdata from S2. Write latency is 2 cycles.
- Forwarding at t+1:
  - First priority: the S2 entry (sample from t-1, write pending) if its address matches.
  - Else: the entry written at cycle t (sample from t-2, missed by read-first) if its address matches.
  - Else: RAM data.
  - Only valid entries participate.
- Out-of-range samples: gind>=GRID_SIZE produces no RAM access and sets drop_err.
- IDLE commands:
  - cmd_clear or cmd_dump moves the FSM to DRAIN and latches the operation. If both are asserted in the same cycle, clear wins.
  - drop_err is cleared when the command is accepted.
  - Commands outside IDLE are ignored.
- DRAIN:
  - hold=1 and busy=1.
  - valid is still accumulated normally.
  - Count resets on any valid. After DRAIN_CYC consecutive idle cycles and an empty S1/S2, go to CLEAR or DUMP.
- CLEAR:
  - Address counter runs 0..GRID_SIZE-1, one per cycle, with mem_wen=1 and wdata=0.
  - After the last address: done=1 for 1 cycle, hold=0, return to IDLE.
- DUMP:
  - Counter a runs 0..GRID_SIZE-1 with mem_ren=1 and mem_raddr=a.
  - One cycle later: dump_valid=1, dump_addr=a, dump_data=mem_rdata.
  - done pulses in the same cycle as the last dump_valid, then return to IDLE.
  - Dump does not clear the grid.
- valid in CLEAR/DUMP: the sample is discarded and drop_err is set.
- rst mid-operation: IDLE on the next cycle, partial clear/dump abandoned, hold=0.

Test Plan:
- Clear: rst, then cmd_clear → hold=1, DRAIN lasts 8 cycles, then 1024 writes addr 0..1023 data 0, done pulse, busy=0.
- Single sample: gind=5, r=0x10000000, i=0x20000000 at t on a cleared grid → mem_wen at t+2, addr 5, data 0x10000000/0x20000000.
- Back-to-back hazard: gind=7 with r=1,2,3 on consecutive cycles → writes 1,3,6. Pattern A,B,A (7,9,7; r=1,5,2) → addr 7 receives 1 then 3 via t-2 forwarding.
- Wrap: cell holds 0xFFFFFFFF, add 2 → 0x00000001. gind=1024 → no write, drop_err=1.
- Dump: cmd_dump while valid still toggling → DRAIN extends until 8 idle cycles, then dump_valid for addr 0..1023 with accumulated values, done pulse on the final beat.
- Misuse: cmd_clear during DUMP → ignored. valid during CLEAR → drop_err=1. rst at clear addr 300 → IDLE next cycle, no further writes.

Source files
------------

// File: rtl/grid_accum_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : grid_accum_ctrl
// Purpose  : Read-modify-write accumulator for the gridding RAM with hazard
//            forwarding, plus drained grid clear / grid dump sequencing.
// Revision : 1.0 - initial release
// ============================================================================
module grid_accum_ctrl #(
    parameter int GRID_SIZE = 1024,
    parameter int AW        = 10,
    parameter int DW        = 32,
    parameter int DRAIN_CYC = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid,
    input  logic [15:0]   gind,
    input  logic [DW-1:0] outdatar,
    input  logic [DW-1:0] outdatai,
    input  logic          cmd_clear,
    input  logic          cmd_dump,
    output logic          hold,
    output logic          busy,
    output logic          done,
    output logic          drop_err,
    output logic          mem_ren,
    output logic [AW-1:0] mem_raddr,
    input  logic [DW-1:0] mem_rdatar,
    input  logic [DW-1:0] mem_rdatai,
    output logic          mem_wen,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdatar,
    output logic [DW-1:0] mem_wdatai,
    output logic          dump_valid,
    output logic [AW-1:0] dump_addr,
    output logic [DW-1:0] dump_datar,
    output logic [DW-1:0] dump_datai
);

    localparam int            CW           = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [AW-1:0] C_LAST_ADDR  = AW'(GRID_SIZE - 1);
    localparam logic [CW-1:0] C_DRAIN_LAST = CW'(DRAIN_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_CLEAR = 2'd2,
        S_DUMP  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_op_clear;
    logic [CW-1:0] r_idle_cnt;
    logic [AW-1:0] r_cnt;

    // S1: sample whose RAM read is in flight
    logic          r_s1_vld;
    logic [AW-1:0] r_s1_addr;
    logic [DW-1:0] r_s1_r;
    logic [DW-1:0] r_s1_i;
    // S2: accumulated sum being written this cycle
    logic          r_s2_vld;
    logic [AW-1:0] r_s2_addr;
    logic [DW-1:0] r_s2_r;
    logic [DW-1:0] r_s2_i;
    // S3: value written last cycle, invisible to a read-first RAM read
    logic          r_s3_vld;
    logic [AW-1:0] r_s3_addr;
    logic [DW-1:0] r_s3_r;
    logic [DW-1:0] r_s3_i;

    logic          r_drop_err;
    logic          r_done;
    logic          r_dump_vld;
    logic [AW-1:0] r_dump_addr;

    logic          w_in_range;
    logic          w_pipe_st;
    logic          w_accept;
    logic          w_drop;
    logic          w_cmd;
    logic          w_drain_done;
    logic          w_seq_st;
    logic [DW-1:0] w_base_r;
    logic [DW-1:0] w_base_i;
    logic [DW-1:0] w_sum_r;
    logic [DW-1:0] w_sum_i;

    assign w_in_range   = ({16'd0, gind} < 32'(GRID_SIZE));
    assign w_pipe_st    = (r_state == S_IDLE) || (r_state == S_DRAIN);
    assign w_accept     = !rst && valid && w_pipe_st && w_in_range;
    assign w_drop       = valid && !(w_pipe_st && w_in_range);
    assign w_cmd        = (r_state == S_IDLE) && (cmd_clear || cmd_dump);
    assign w_seq_st     = (r_state == S_CLEAR) || (r_state == S_DUMP);
    assign w_drain_done = (r_state == S_DRAIN) && !valid && (r_idle_cnt == C_DRAIN_LAST)
                          && !r_s1_vld && !r_s2_vld;

    // Newest pending value for the S1 address wins over older ones and RAM
    always_comb begin
        w_base_r = mem_rdatar;
        w_base_i = mem_rdatai;
        if (r_s2_vld && (r_s2_addr == r_s1_addr)) begin
            w_base_r = r_s2_r;
            w_base_i = r_s2_i;
        end else if (r_s3_vld && (r_s3_addr == r_s1_addr)) begin
            w_base_r = r_s3_r;
            w_base_i = r_s3_i;
        end
    end

    assign w_sum_r = w_base_r + r_s1_r;
    assign w_sum_i = w_base_i + r_s1_i;

    always_comb begin
        w_state_nxt = r_state;
        hold        = 1'b0;
        busy        = 1'b0;
        mem_ren     = 1'b0;
        mem_raddr   = '0;
        mem_wen     = 1'b0;
        mem_waddr   = '0;
        mem_wdatar  = '0;
        mem_wdatai  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_cmd) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                hold = 1'b1;
                busy = 1'b1;
                if (w_drain_done) begin
                    w_state_nxt = r_op_clear ? S_CLEAR : S_DUMP;
                end
            end
            S_CLEAR, S_DUMP: begin
                hold = 1'b1;
                busy = 1'b1;
                if (r_cnt == C_LAST_ADDR) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_accept) begin
            mem_ren   = 1'b1;
            mem_raddr = gind[AW-1:0];
        end else if ((r_state == S_DUMP) && !rst) begin
            mem_ren   = 1'b1;
            mem_raddr = r_cnt;
        end

        // S1/S2 are empty whenever CLEAR runs, so the two write sources never overlap
        if ((r_state == S_CLEAR) && !rst) begin
            mem_wen   = 1'b1;
            mem_waddr = r_cnt;
        end else if (r_s2_vld && !rst) begin
            mem_wen    = 1'b1;
            mem_waddr  = r_s2_addr;
            mem_wdatar = r_s2_r;
            mem_wdatai = r_s2_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_s1_vld  <= 1'b0;
            r_s1_addr <= '0;
            r_s1_r    <= '0;
            r_s1_i    <= '0;
            r_s2_vld  <= 1'b0;
            r_s2_addr <= '0;
            r_s2_r    <= '0;
            r_s2_i    <= '0;
            r_s3_vld  <= 1'b0;
            r_s3_addr <= '0;
            r_s3_r    <= '0;
            r_s3_i    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_s1_addr <= gind[AW-1:0];
                r_s1_r    <= outdatar;
                r_s1_i    <= outdatai;
            end
            r_s2_vld  <= r_s1_vld;
            r_s2_addr <= r_s1_addr;
            r_s2_r    <= w_sum_r;
            r_s2_i    <= w_sum_i;
            r_s3_vld  <= r_s2_vld;
            r_s3_addr <= r_s2_addr;
            r_s3_r    <= r_s2_r;
            r_s3_i    <= r_s2_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_clear  <= 1'b0;
            r_idle_cnt  <= '0;
            r_cnt       <= '0;
            r_drop_err  <= 1'b0;
            r_done      <= 1'b0;
            r_dump_vld  <= 1'b0;
            r_dump_addr <= '0;
        end else begin
            if (w_cmd) begin
                r_op_clear <= cmd_clear;
                r_idle_cnt <= '0;
            end else if (r_state == S_DRAIN) begin
                if (valid) begin
                    r_idle_cnt <= '0;
                end else if (r_idle_cnt != C_DRAIN_LAST) begin
                    r_idle_cnt <= r_idle_cnt + CW'(1);
                end
            end

            r_cnt       <= w_seq_st ? (r_cnt + AW'(1)) : '0;
            r_done      <= w_seq_st && (r_cnt == C_LAST_ADDR);
            r_dump_vld  <= (r_state == S_DUMP);
            r_dump_addr <= r_cnt;

            // A drop in the command cycle is still reported
            if (w_cmd) begin
                r_drop_err <= 1'b0;
            end
            if (w_drop) begin
                r_drop_err <= 1'b1;
            end
        end
    end

    assign done       = r_done;
    assign drop_err   = r_drop_err;
    assign dump_valid = r_dump_vld;
    assign dump_addr  = r_dump_addr;
    assign dump_datar = r_dump_vld ? mem_rdatar : '0;
    assign dump_datai = r_dump_vld ? mem_rdatai : '0;

endmodule
`default_nettype wire

// File: tb/tb_grid_accum_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_grid_accum_ctrl
// Purpose  : Randomised bench for grid_accum_ctrl against a grid-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_grid_accum_ctrl;

    localparam int GRID_SIZE = 1024;
    localparam int AW        = 10;
    localparam int DW        = 32;
    localparam int DRAIN_CYC = 8;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          valid     = 1'b0;
    logic [15:0]   gind      = '0;
    logic [DW-1:0] outdatar  = '0;
    logic [DW-1:0] outdatai  = '0;
    logic          cmd_clear = 1'b0;
    logic          cmd_dump  = 1'b0;
    logic          hold, busy, done, drop_err;
    logic          mem_ren, mem_wen, dump_valid;
    logic [AW-1:0] mem_raddr, mem_waddr, dump_addr;
    logic [DW-1:0] mem_rdatar = '0;
    logic [DW-1:0] mem_rdatai = '0;
    logic [DW-1:0] mem_wdatar, mem_wdatai, dump_datar, dump_datai;

    always #5 clk = ~clk;

    grid_accum_ctrl #(
        .GRID_SIZE(GRID_SIZE), .AW(AW), .DW(DW), .DRAIN_CYC(DRAIN_CYC)
    ) u_dut (
        .clk(clk), .rst(rst), .valid(valid), .gind(gind),
        .outdatar(outdatar), .outdatai(outdatai),
        .cmd_clear(cmd_clear), .cmd_dump(cmd_dump),
        .hold(hold), .busy(busy), .done(done), .drop_err(drop_err),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr),
        .mem_rdatar(mem_rdatar), .mem_rdatai(mem_rdatai),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr),
        .mem_wdatar(mem_wdatar), .mem_wdatai(mem_wdatai),
        .dump_valid(dump_valid), .dump_addr(dump_addr),
        .dump_datar(dump_datar), .dump_datai(dump_datai)
    );

    // Grid RAM: registered read, read-first on collision
    logic [DW-1:0] ram_r [GRID_SIZE];
    logic [DW-1:0] ram_i [GRID_SIZE];
    always @(posedge clk) begin
        if (mem_ren) begin
            mem_rdatar <= ram_r[mem_raddr];
            mem_rdatai <= ram_i[mem_raddr];
        end
        if (mem_wen) begin
            ram_r[mem_waddr] <= mem_wdatar;
            ram_i[mem_waddr] <= mem_wdatai;
        end
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- grid-level reference model ----------------
    typedef struct {
        int          due;
        int          addr;
        logic [31:0] r;
        logic [31:0] i;
    } wr_t;

    wr_t         pend[$];
    logic [31:0] g_r [GRID_SIZE];
    logic [31:0] g_i [GRID_SIZE];
    int          m_mode;      // 0 accumulate, 1 drain, 2 clear, 3 dump
    bit          m_op_clear;
    int          m_quiet;
    int          m_pos;
    bit          m_drop;
    bit          m_done_nx;
    bit          m_dv_nx;
    int          m_dv_addr;
    logic [31:0] m_dv_r, m_dv_i;
    bit          m_acc, e_wen, e_ren, from_pend;
    int          e_waddr, e_raddr, m_a;
    logic [31:0] e_wr, e_wi, b_r, b_i;

    initial begin
        for (int k = 0; k < GRID_SIZE; k++) begin
            g_r[k] = '0;
            g_i[k] = '0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            m_mode    = 0;
            m_quiet   = 0;
            m_pos     = 0;
            m_drop    = 1'b0;
            m_done_nx = 1'b0;
            m_dv_nx   = 1'b0;
            pend.delete();
        end else begin
            m_acc = valid && (m_mode < 2) && (gind < GRID_SIZE);
            chk("hold", hold, m_mode != 0);
            chk("busy", busy, m_mode != 0);
            chk("done", done, m_done_nx);
            chk("drop_err", drop_err, m_drop);

            e_ren   = m_acc || (m_mode == 3);
            e_raddr = m_acc ? int'(gind) : m_pos;
            chk("mem_ren", mem_ren, e_ren);
            if (e_ren) chk("mem_raddr", mem_raddr, e_raddr);

            e_wen = 1'b0;
            from_pend = 1'b0;
            if (m_mode == 2) begin
                e_wen = 1'b1; e_waddr = m_pos; e_wr = '0; e_wi = '0;
            end else if (pend.size() > 0 && pend[0].due == cyc) begin
                e_wen = 1'b1; e_waddr = pend[0].addr; e_wr = pend[0].r; e_wi = pend[0].i;
                from_pend = 1'b1;
            end
            chk("mem_wen", mem_wen, e_wen);
            if (e_wen) begin
                chk("mem_waddr", mem_waddr, e_waddr);
                chk("mem_wdatar", mem_wdatar, e_wr);
                chk("mem_wdatai", mem_wdatai, e_wi);
            end

            chk("dump_valid", dump_valid, m_dv_nx);
            if (m_dv_nx) begin
                chk("dump_addr", dump_addr, m_dv_addr);
                chk("dump_datar", dump_datar, m_dv_r);
                chk("dump_datai", dump_datai, m_dv_i);
            end

            // advance the model by one cycle
            if (e_wen) begin
                g_r[e_waddr] = e_wr;
                g_i[e_waddr] = e_wi;
                if (from_pend) void'(pend.pop_front());
            end
            m_dv_nx = (m_mode == 3);
            if (m_dv_nx) begin
                m_dv_addr = m_pos; m_dv_r = g_r[m_pos]; m_dv_i = g_i[m_pos];
            end
            m_done_nx = (m_mode >= 2) && (m_pos == GRID_SIZE - 1);
            if (m_acc) begin
                m_a = int'(gind);
                b_r = g_r[m_a];
                b_i = g_i[m_a];
                foreach (pend[j]) if (pend[j].addr == m_a) begin
                    b_r = pend[j].r;
                    b_i = pend[j].i;
                end
                pend.push_back('{due: cyc + 2, addr: m_a, r: b_r + outdatar, i: b_i + outdatai});
            end
            if (m_mode == 0 && (cmd_clear || cmd_dump)) m_drop = 1'b0;
            if (valid && !m_acc) m_drop = 1'b1;
            case (m_mode)
                0: if (cmd_clear || cmd_dump) begin
                    m_mode = 1; m_op_clear = cmd_clear; m_quiet = 0;
                end
                1: begin
                    m_quiet = valid ? 0 : m_quiet + 1;
                    if (m_quiet >= DRAIN_CYC && pend.size() == 0) begin
                        m_mode = m_op_clear ? 2 : 3;
                        m_pos  = 0;
                    end
                end
                default: begin
                    if (m_pos == GRID_SIZE - 1) begin
                        m_mode = 0;
                        m_pos  = 0;
                    end else begin
                        m_pos++;
                    end
                end
            endcase
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        valid = 1'b0; cmd_clear = 1'b0; cmd_dump = 1'b0;
    endtask

    task automatic send(input logic [15:0] g, input logic [31:0] r, input logic [31:0] i);
        valid = 1'b1; gind = g; outdatar = r; outdatai = i;
    endtask

    task automatic rnd_sample(input bit allow_oob);
        valid    = ($urandom_range(1) == 1);
        gind     = (allow_oob && $urandom_range(15) == 0) ? 16'($urandom_range(65535, 1024))
                                                          : 16'($urandom_range(63));
        outdatar = $urandom;
        outdatai = $urandom;
    endtask

    task automatic wait_done(input int budget, input string nm);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, done, 1'b1);
    endtask

    task automatic chk_wr(input string nm, input int a, input logic [31:0] d);
        chk(nm, {mem_wen, 21'd0, mem_waddr, mem_wdatar}, {1'b1, 21'd0, 10'(a), d});
    endtask

    initial begin
        int n;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_flags", {hold, busy, done, drop_err}, 4'b0000);
        chk("reset_mem", {mem_ren, mem_wen, dump_valid}, 3'b000);

        // clear with exact drain length
        tick(); cmd_clear = 1'b1;
        tick(); idle_in();
        @(negedge clk);
        chk("drain_hold", hold, 1'b1);
        repeat (7) @(negedge clk);
        chk("drain_last_no_wr", mem_wen, 1'b0);
        @(negedge clk);
        chk_wr("clear_first", 0, 32'h0);
        wait_done(1100, "clear1_done");
        chk("clear1_busy", busy, 1'b0);

        // single sample: write lands two cycles later
        tick(); send(16'd5, 32'h1000_0000, 32'h2000_0000);
        tick(); idle_in();
        @(negedge clk);
        chk("single_no_early", mem_wen, 1'b0);
        tick(); @(negedge clk);
        chk_wr("single_wr", 5, 32'h1000_0000);
        chk("single_wi", mem_wdatai, 32'h2000_0000);

        // back-to-back same address
        tick(); send(16'd7, 32'd1, 32'd0);
        tick(); send(16'd7, 32'd2, 32'd0);
        tick(); send(16'd7, 32'd3, 32'd0);
        @(negedge clk); chk_wr("b2b_1", 7, 32'd1);
        tick(); idle_in();
        @(negedge clk); chk_wr("b2b_3", 7, 32'd3);
        tick(); @(negedge clk); chk_wr("b2b_6", 7, 32'd6);

        // A,B,A: second A needs the value written two cycles earlier
        tick(); send(16'd20, 32'd1, 32'd0);
        tick(); send(16'd22, 32'd5, 32'd0);
        tick(); send(16'd20, 32'd2, 32'd0);
        @(negedge clk); chk_wr("aba_a1", 20, 32'd1);
        tick(); idle_in();
        @(negedge clk); chk_wr("aba_b", 22, 32'd5);
        tick(); @(negedge clk); chk_wr("aba_a3", 20, 32'd3);

        // wrap through RAM path and through forwarding
        tick(); send(16'd31, 32'hFFFF_FFFF, 32'h0);
        tick(); idle_in();
        repeat (4) tick();
        send(16'd31, 32'd2, 32'd0);
        tick(); idle_in();
        tick(); @(negedge clk); chk_wr("wrap_ram", 31, 32'd1);
        tick(); send(16'd32, 32'hFFFF_FFFF, 32'h0);
        tick(); send(16'd32, 32'd2, 32'd0);
        tick(); idle_in();
        tick(); @(negedge clk); chk_wr("wrap_fwd", 32, 32'd1);

        // out-of-range index
        tick(); send(16'd1024, 32'd9, 32'd9);
        tick(); idle_in();
        @(negedge clk); chk("oob_drop", drop_err, 1'b1);
        tick(); @(negedge clk); chk("oob_no_wr", mem_wen, 1'b0);

        // random accumulation
        for (int k = 0; k < 400; k++) begin
            tick(); rnd_sample(1'b1);
        end

        // dump with traffic still arriving; drop flag cleared on accept
        tick(); send(16'd2000, 32'd1, 32'd1);
        tick(); rnd_sample(1'b0); cmd_dump = 1'b1;
        tick(); cmd_dump = 1'b0; rnd_sample(1'b0);
        @(negedge clk); chk("cmd_clears_drop", drop_err, 1'b0);
        for (int k = 0; k < 20; k++) begin
            tick(); rnd_sample(1'b0);
        end
        tick(); idle_in();
        n = 0;
        while (!dump_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("dump_start", {dump_valid, dump_addr}, {1'b1, 10'd0});
        tick(); cmd_clear = 1'b1; send(16'd3, 32'd7, 32'd7);
        tick(); idle_in();
        wait_done(1100, "dump1_done");
        tick(); @(negedge clk);
        chk("dump_drop", drop_err, 1'b1);
        chk("dump_ignored_clear", busy, 1'b0);
        for (int k = 0; k < 12; k++) begin
            tick(); @(negedge clk);
            chk("no_clear_after_dump", mem_wen, 1'b0);
        end

        // clear with a stray sample, then reset mid-clear
        tick(); cmd_clear = 1'b1;
        tick(); idle_in();
        n = 0;
        while (!(mem_wen && hold) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("clear2_started", mem_wen, 1'b1);
        tick(); send(16'd5, 32'd1, 32'd1);
        tick(); idle_in();
        @(negedge clk); chk("clear_drop", drop_err, 1'b1);
        n = 0;
        while (!(mem_wen && mem_waddr == 10'd300) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("clear_at_300", {mem_wen, mem_waddr}, {1'b1, 10'd300});
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("rst_abort", {hold, busy, mem_wen}, 3'b000);
        for (int k = 0; k < 10; k++) begin
            tick(); @(negedge clk);
            chk("rst_no_wr", mem_wen, 1'b0);
        end

        // full clear, more traffic, final dump of the whole grid
        tick(); cmd_clear = 1'b1;
        tick(); idle_in();
        wait_done(1200, "clear3_done");
        for (int k = 0; k < 300; k++) begin
            tick(); rnd_sample(1'b1);
        end
        tick(); idle_in(); cmd_dump = 1'b1;
        tick(); idle_in();
        wait_done(1200, "dump2_done");
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
